// File: rtl/lite16_pkg.sv
// lite16_pkg: shared encodings, field positions and bundle type for the lite16 decode stage
package lite16_pkg;
  localparam int WORD = 16;
  localparam int REG_COUNT = 8;
  localparam int AW = 3;
  localparam int CLS_HI = 15, CLS_LO = 14;
  localparam int OP_HI = 13, OP_LO = 11;
  localparam int DST_HI = 10, DST_LO = 8;
  localparam int SA_HI = 7, SA_LO = 5;
  localparam int SB_HI = 4, SB_LO = 2;
  localparam int IMM_HI = 7, IMM_LO = 0;
  typedef enum logic [1:0] {CLS_R = 2'b00, CLS_I = 2'b01, CLS_CMP = 2'b10, CLS_ILL = 2'b11} cls_e;
  typedef struct packed {
    logic [2:0]      codeop;
    logic [WORD-1:0] a;
    logic [WORD-1:0] b;
    logic [WORD-1:0] rd;
    logic            ri;
    logic [AW-1:0]   dst;
    logic            wr_en;
    logic            is_cmp;
  } bundle_t;
  // R0 is never tracked, so its one-hot mask is empty
  function automatic logic [REG_COUNT-1:0] onehot(input logic [AW-1:0] r);
    return (r == '0) ? '0 : ({{(REG_COUNT-1){1'b0}}, 1'b1} << r);
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch handshake, write-back port and ALU operand bundle
interface decode_stage_if;
  import lite16_pkg::*;
  logic            instr_valid;
  logic [WORD-1:0] instr;
  logic            instr_ready;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [WORD-1:0] wb_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [2:0]      codeop;
  logic [WORD-1:0] a;
  logic [WORD-1:0] b;
  logic [WORD-1:0] rd;
  logic            ri;
  logic [AW-1:0]   dst;
  logic            wr_en;
  logic            is_cmp;
  logic            illegal;
  modport slave (
    input  instr_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
    output instr_ready, ex_valid, codeop, a, b, rd, ri, dst, wr_en, is_cmp, illegal
  );
  modport master (
    output instr_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
    input  instr_ready, ex_valid, codeop, a, b, rd, ri, dst, wr_en, is_cmp, illegal
  );
endinterface

// File: rtl/lite16_regfile.sv
// lite16_regfile: 8x16 register file, two read ports with write-back bypass, R0 hardwired to 0
module lite16_regfile import lite16_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra_i,
  input  logic [AW-1:0]   rb_i,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [WORD-1:0] wd_i,
  output logic [WORD-1:0] rda_o,
  output logic [WORD-1:0] rdb_o
);
  logic [WORD-1:0] mem_q [REG_COUNT];
  // commit write-back on the edge; R0 is never written
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
    else if (we_i && wa_i != '0)
      mem_q[wa_i] <= wd_i;
  assign rda_o = (ra_i == '0) ? '0 : (we_i && wa_i == ra_i) ? wd_i : mem_q[ra_i];
  assign rdb_o = (rb_i == '0) ? '0 : (we_i && wa_i == rb_i) ? wd_i : mem_q[rb_i];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: lite16 decoder with register scoreboard, hazard stall and registered ALU bundle
module decode_stage import lite16_pkg::*; (
  input logic clk,
  input logic rst_n,
  decode_stage_if.slave io
);
  cls_e                 cls;
  logic [2:0]           op;
  logic [AW-1:0]        dst, sa, sb, ra;
  logic [7:0]           imm;
  logic [WORD-1:0]      rda, rdb;
  logic [REG_COUNT-1:0] pend_q, pend_d, clr, set, busy;
  bundle_t              bun_q, bun_d;
  logic                 ex_valid_q, illegal_q, hazard, ready, acc, legal;
  assign cls   = cls_e'(io.instr[CLS_HI:CLS_LO]);
  assign op    = io.instr[OP_HI:OP_LO];
  assign dst   = io.instr[DST_HI:DST_LO];
  assign sa    = io.instr[SA_HI:SA_LO];
  assign sb    = io.instr[SB_HI:SB_LO];
  assign imm   = io.instr[IMM_HI:IMM_LO];
  assign legal = cls != CLS_ILL;
  // I-type only reads R[dst] (for rd), so port A is shared between srcA and dst
  assign ra    = (cls == CLS_I) ? dst : sa;
  lite16_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra_i  (ra),
    .rb_i  (sb),
    .we_i  (io.wb_en),
    .wa_i  (io.wb_addr),
    .wd_i  (io.wb_data),
    .rda_o (rda),
    .rdb_o (rdb)
  );
  // scoreboard update and hazard; the bundle still waiting in the output register counts as busy
  always_comb begin
    clr    = io.wb_en ? onehot(io.wb_addr) : '0;
    set    = (ex_valid_q && io.ex_ready && bun_q.wr_en) ? onehot(bun_q.dst) : '0;
    pend_d = (pend_q & ~clr) | set;
    busy   = (pend_q & ~clr) | ((ex_valid_q && bun_q.wr_en) ? onehot(bun_q.dst) : '0);
    hazard = ((cls == CLS_R || cls == CLS_CMP) && (busy[sa] || busy[sb])) ||
             ((cls == CLS_R || cls == CLS_I) && busy[dst]);
    ready  = rst_n && (!ex_valid_q || io.ex_ready) && !hazard;
    acc    = io.instr_valid && ready;
  end
  // operand bundle for the instruction currently offered
  always_comb begin
    bun_d        = '0;
    bun_d.codeop = op;
    bun_d.a      = (cls == CLS_I) ? '0 : rda;
    bun_d.b      = (cls == CLS_I) ? {8'h00, imm} : rdb;
    bun_d.rd     = (cls == CLS_I && op[0]) ? {rda[WORD-1:8], 8'h00} : '0;
    bun_d.ri     = cls == CLS_I;
    bun_d.dst    = (cls == CLS_CMP) ? '0 : dst;
    bun_d.wr_en  = cls != CLS_CMP;
    bun_d.is_cmp = cls == CLS_CMP;
  end
  // output register, sticky illegal flag and pending bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      pend_q     <= '0;
      bun_q      <= '0;
    end else begin
      pend_q <= pend_d;
      if (acc && !legal) illegal_q <= 1'b1;
      if (!ex_valid_q || io.ex_ready) ex_valid_q <= acc && legal;
      if (acc && legal) bun_q <= bun_d;
    end
  assign io.instr_ready = ready;
  assign io.ex_valid    = ex_valid_q;
  assign io.codeop      = bun_q.codeop;
  assign io.a           = bun_q.a;
  assign io.b           = bun_q.b;
  assign io.rd          = bun_q.rd;
  assign io.ri          = bun_q.ri;
  assign io.dst         = bun_q.dst;
  assign io.wr_en       = bun_q.wr_en;
  assign io.is_cmp      = bun_q.is_cmp;
  assign io.illegal     = illegal_q;
endmodule
